// File: rtl/pll_lock_supervisor_if.sv
`timescale 1ns/1ps
// PLL supervisor signal bundle: raw lock and restart in, PLL pin controls and status out.
// The supervisor takes the master view; the PLL wrapper and system logic take the slave view.
interface pll_lock_supervisor_if #(
   parameter int CNT_WIDTH = 8
);
   logic                 locked_in;
   logic                 restart;
   logic                 pll_resetb;
   logic                 pll_bypass;
   logic                 sys_reset_n;
   logic                 locked;
   logic                 fault;
   logic [2:0]           state;
   logic [CNT_WIDTH-1:0] retry_count;
   logic [CNT_WIDTH-1:0] loss_count;

   modport master (
      input  locked_in, restart,
      output pll_resetb, pll_bypass, sys_reset_n, locked, fault, state, retry_count, loss_count
   );

   modport slave (
      output locked_in, restart,
      input  pll_resetb, pll_bypass, sys_reset_n, locked, fault, state, retry_count, loss_count
   );
endinterface

// File: rtl/pll_lock_supervisor.sv
`timescale 1ns/1ps
// Sequences SB_PLL40 RESETB, qualifies LOCK over a stability window, retries on timeout
// and drives the design-wide reset from the reference clock domain.
//
// state      | meaning
// RESET_PLL  | PLL held in reset for RESET_CYCLES
// WAIT_LOCK  | PLL released, waiting up to LOCK_TIMEOUT for lock
// STABLE     | lock seen, must hold STABLE_CYCLES in a row
// RUN        | lock qualified, system reset released
// FAULT      | retries exhausted, optional bypass onto the reference clock
module pll_lock_supervisor #(
   parameter int RESET_CYCLES    = 16,
   parameter int LOCK_TIMEOUT    = 4096,
   parameter int STABLE_CYCLES   = 256,
   parameter int MAX_RETRIES     = 3,
   parameter int CNT_WIDTH       = 8,
   parameter int SYNC_STAGES     = 2,
   parameter int BYPASS_ON_FAULT = 1
) (
   input  logic                    clock_in,
   input  logic                    reset_n,
   pll_lock_supervisor_if.master   bus
);

   typedef enum logic [2:0] {
      S_RESET_PLL = 3'd0,
      S_WAIT_LOCK = 3'd1,
      S_STABLE    = 3'd2,
      S_RUN       = 3'd3,
      S_FAULT     = 3'd4
   } state_t;

   localparam int MAX_AB  = (RESET_CYCLES > LOCK_TIMEOUT) ? RESET_CYCLES : LOCK_TIMEOUT;
   localparam int MAX_CYC = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
   localparam int CW      = $clog2(MAX_CYC + 1);

   localparam logic [CW-1:0]        RESET_TC    = CW'(RESET_CYCLES - 1);
   localparam logic [CW-1:0]        LOCK_TC     = CW'(LOCK_TIMEOUT - 1);
   localparam logic [CW-1:0]        STABLE_TC   = CW'(STABLE_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] RETRY_LIMIT = CNT_WIDTH'(MAX_RETRIES);
   localparam logic                 BYPASS_EN   = (BYPASS_ON_FAULT != 0);

   state_t                 state_q, state_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [CNT_WIDTH-1:0]   retry_q, retry_d;
   logic [CNT_WIDTH-1:0]   loss_q, loss_d;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   lk_s;
   logic                   pll_resetb_q, pll_bypass_q, sys_reset_n_q, locked_q, fault_q;

   assign lk_s = sync_q[SYNC_STAGES-1];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 1'b1;
      retry_d = retry_q;
      loss_d  = loss_q;
      if (bus.restart) begin
         state_d = S_RESET_PLL;
         cnt_d   = '0;
         retry_d = '0;
      end else begin
         case (state_q)
            S_RESET_PLL: begin
               if (cnt_q == RESET_TC) begin
                  state_d = S_WAIT_LOCK;
                  cnt_d   = '0;
               end
            end
            S_WAIT_LOCK: begin
               if (lk_s) begin
                  state_d = S_STABLE;
                  cnt_d   = '0;
               end else if (cnt_q == LOCK_TC) begin
                  cnt_d = '0;
                  if (retry_q < RETRY_LIMIT) begin
                     retry_d = retry_q + 1'b1;
                     state_d = S_RESET_PLL;
                  end else begin
                     state_d = S_FAULT;
                  end
               end
            end
            S_STABLE: begin
               // A dropout restarts the lock wait without charging a retry.
               if (!lk_s) begin
                  state_d = S_WAIT_LOCK;
                  cnt_d   = '0;
               end else if (cnt_q == STABLE_TC) begin
                  state_d = S_RUN;
                  cnt_d   = '0;
                  retry_d = '0;
               end
            end
            S_RUN: begin
               cnt_d = '0;
               if (!lk_s) begin
                  state_d = S_RESET_PLL;
                  loss_d  = (loss_q == '1) ? loss_q : loss_q + 1'b1;
               end
            end
            S_FAULT: begin
               cnt_d = '0;
            end
            default: begin
               state_d = S_RESET_PLL;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // Outputs are decoded from the next state so they change on the entering edge.
   always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= S_RESET_PLL;
         cnt_q         <= '0;
         retry_q       <= '0;
         loss_q        <= '0;
         sync_q        <= '0;
         pll_resetb_q  <= 1'b0;
         pll_bypass_q  <= 1'b0;
         sys_reset_n_q <= 1'b0;
         locked_q      <= 1'b0;
         fault_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         retry_q       <= retry_d;
         loss_q        <= loss_d;
         sync_q        <= {sync_q[SYNC_STAGES-2:0], bus.locked_in};
         pll_resetb_q  <= (state_d == S_WAIT_LOCK) || (state_d == S_STABLE) || (state_d == S_RUN);
         pll_bypass_q  <= BYPASS_EN && (state_d == S_FAULT);
         sys_reset_n_q <= (state_d == S_RUN) || (BYPASS_EN && (state_d == S_FAULT));
         locked_q      <= (state_d == S_RUN);
         fault_q       <= (state_d == S_FAULT);
      end
   end

   assign bus.state       = state_q;
   assign bus.retry_count = retry_q;
   assign bus.loss_count  = loss_q;
   assign bus.pll_resetb  = pll_resetb_q;
   assign bus.pll_bypass  = pll_bypass_q;
   assign bus.sys_reset_n = sys_reset_n_q;
   assign bus.locked      = locked_q;
   assign bus.fault       = fault_q;

endmodule
